// File: rtl/axis_matmul_engine.sv
// rtl/axis_matmul_engine.sv - streaming signed matrix multiply C = A*B over AXI-Stream
module axis_matmul_engine #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int MAX_DIM = 8,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [DIM_W-1:0]  cfg_k,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic              s_axis_a_tlast,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic              m_axis_c_tlast,
  output logic [ACC_W-1:0]  m_axis_c_tdata
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT,
    S_FINISH
  } state_t;

  state_t state;

  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [CNT_W-1:0] a_total, b_total, a_cnt, b_cnt;
  logic [DIM_W-1:0] row, col, mac_cnt;
  logic signed [ACC_W-1:0] acc;

  logic signed [DATA_W-1:0] a_mem [DEPTH];
  logic signed [DATA_W-1:0] b_mem [DEPTH];

  logic a_fire, b_fire, c_fire, cfg_bad, last_elem;
  logic [CNT_W-1:0] a_cnt_next, b_cnt_next;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic signed [DATA_W-1:0] a_elem, b_elem;
  logic signed [ACC_W-1:0] a_ext, b_ext, prod, acc_sum;

  // Each input stream accepts beats only until its own expected count is reached.
  assign s_axis_a_tready = (state == S_LOAD) && (a_cnt < a_total);
  assign s_axis_b_tready = (state == S_LOAD) && (b_cnt < b_total);

  assign a_fire = s_axis_a_tvalid && s_axis_a_tready;
  assign b_fire = s_axis_b_tvalid && s_axis_b_tready;
  assign c_fire = m_axis_c_tvalid && m_axis_c_tready;

  assign a_cnt_next = a_cnt + CNT_W'(a_fire);
  assign b_cnt_next = b_cnt + CNT_W'(b_fire);

  assign cfg_bad = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0) ||
                   (cfg_m > DIM_W'(MAX_DIM)) || (cfg_n > DIM_W'(MAX_DIM)) ||
                   (cfg_k > DIM_W'(MAX_DIM));

  assign busy = (state != S_IDLE);

  assign last_elem = (row == m_q - DIM_W'(1)) && (col == n_q - DIM_W'(1));

  // Row-major buffer addressing: A[row][k] at row*K+k, B[k][col] at k*N+col.
  assign a_idx = IDX_W'(row) * IDX_W'(k_q) + IDX_W'(mac_cnt);
  assign b_idx = IDX_W'(mac_cnt) * IDX_W'(n_q) + IDX_W'(col);

  assign a_elem = a_mem[a_idx];
  assign b_elem = b_mem[b_idx];

  // Operands are sign-extended first so the product wraps modulo 2^ACC_W.
  assign a_ext   = ACC_W'(a_elem);
  assign b_ext   = ACC_W'(b_elem);
  assign prod    = a_ext * b_ext;
  assign acc_sum = acc + prod;

  // Buffer incoming beats; the running beat count is the row-major index.
  always_ff @(posedge clk) begin
    if (a_fire) a_mem[a_cnt[IDX_W-1:0]] <= s_axis_a_tdata;
    if (b_fire) b_mem[b_cnt[IDX_W-1:0]] <= s_axis_b_tdata;
  end

  // Control FSM: load, one MAC per cycle per element, hold C until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      m_q             <= '0;
      n_q             <= '0;
      k_q             <= '0;
      a_total         <= '0;
      b_total         <= '0;
      a_cnt           <= '0;
      b_cnt           <= '0;
      row             <= '0;
      col             <= '0;
      mac_cnt         <= '0;
      acc             <= '0;
      m_axis_c_tvalid <= 1'b0;
      m_axis_c_tdata  <= '0;
      m_axis_c_tlast  <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err     <= 1'b0;
            m_q     <= cfg_m;
            n_q     <= cfg_n;
            k_q     <= cfg_k;
            a_total <= CNT_W'(cfg_m) * CNT_W'(cfg_k);
            b_total <= CNT_W'(cfg_k) * CNT_W'(cfg_n);
            a_cnt   <= '0;
            b_cnt   <= '0;
            state   <= cfg_bad ? S_FINISH : S_LOAD;
          end
        end
        S_LOAD: begin
          a_cnt <= a_cnt_next;
          b_cnt <= b_cnt_next;
          // Framing is by count; tlast only has to agree with it.
          if (a_fire && (s_axis_a_tlast != (a_cnt_next == a_total))) err <= 1'b1;
          if (b_fire && (s_axis_b_tlast != (b_cnt_next == b_total))) err <= 1'b1;
          if ((a_cnt_next == a_total) && (b_cnt_next == b_total)) begin
            state   <= S_COMPUTE;
            row     <= '0;
            col     <= '0;
            mac_cnt <= '0;
            acc     <= '0;
          end
        end
        S_COMPUTE: begin
          acc <= acc_sum;
          if (mac_cnt == k_q - DIM_W'(1)) begin
            state           <= S_OUTPUT;
            m_axis_c_tvalid <= 1'b1;
            m_axis_c_tdata  <= acc_sum;
            m_axis_c_tlast  <= last_elem;
          end else begin
            mac_cnt <= mac_cnt + DIM_W'(1);
          end
        end
        S_OUTPUT: begin
          if (c_fire) begin
            m_axis_c_tvalid <= 1'b0;
            mac_cnt         <= '0;
            acc             <= '0;
            if (last_elem) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state <= S_COMPUTE;
              if (col == n_q - DIM_W'(1)) begin
                col <= '0;
                row <= row + DIM_W'(1);
              end else begin
                col <= col + DIM_W'(1);
              end
            end
          end
        end
        S_FINISH: begin
          // Arriving with done already high means a normal run; otherwise the
          // config was rejected and the pulse plus error are raised here.
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
            err  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_matmul_engine.sv
// tb/tb_axis_matmul_engine.sv - directed self-checking bench for axis_matmul_engine
module tb_axis_matmul_engine;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int DIM_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DIM_W-1:0] cfg_m = '0, cfg_n = '0, cfg_k = '0;
  logic a_tvalid = 1'b0, a_tlast = 1'b0;
  logic [DATA_W-1:0] a_tdata = '0;
  logic b_tvalid = 1'b0, b_tlast = 1'b0;
  logic [DATA_W-1:0] b_tdata = '0;
  logic c_tready = 1'b0;

  logic a_tready, b_tready, c_tvalid, c_tlast, busy, done, err;
  logic [ACC_W-1:0] c_tdata;
  logic a_tready32, b_tready32, c_tvalid32, c_tlast32, busy32, done32, err32;
  logic [31:0] c_tdata32;

  int n_checks = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] a_vec [64];
  logic [DATA_W-1:0] b_vec [64];
  logic [ACC_W-1:0]  got_c [64];
  logic [31:0]       got_c32 [64];
  logic              got_last [64];
  int                got_cyc [64];
  int n_got, done_cyc, err_at_done, err_first, first_rdy_cyc, last_load_cyc;
  int first_vld_cyc, last_c_cyc, stall_viol, timed_out;

  always #5 clk = ~clk;

  axis_matmul_engine #(.DATA_W(16), .ACC_W(40), .MAX_DIM(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy), .done(done), .err(err),
    .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready),
    .s_axis_a_tlast(a_tlast), .s_axis_a_tdata(a_tdata),
    .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready),
    .s_axis_b_tlast(b_tlast), .s_axis_b_tdata(b_tdata),
    .m_axis_c_tvalid(c_tvalid), .m_axis_c_tready(c_tready),
    .m_axis_c_tlast(c_tlast), .m_axis_c_tdata(c_tdata)
  );

  axis_matmul_engine #(.DATA_W(16), .ACC_W(32), .MAX_DIM(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy32), .done(done32), .err(err32),
    .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(a_tready32),
    .s_axis_a_tlast(a_tlast), .s_axis_a_tdata(a_tdata),
    .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(b_tready32),
    .s_axis_b_tlast(b_tlast), .s_axis_b_tdata(b_tdata),
    .m_axis_c_tvalid(c_tvalid32), .m_axis_c_tready(c_tready),
    .m_axis_c_tlast(c_tlast32), .m_axis_c_tdata(c_tdata32)
  );

  // Drives one job; cycle 0 is the first cycle after the start cycle.
  task automatic run_job(input int m, input int n, input int k, input int bad_b_beat,
                         input bit rand_rdy, input int stop_after);
    int ai = 0, bi = 0, cyc = 0;
    int na = m * k;
    int nb = k * n;
    bit a_f, b_f, c_f, stop = 0, seen_done = 0, prev_stall = 0;
    logic [ACC_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    n_got = 0; done_cyc = -1; err_at_done = -1; first_rdy_cyc = -1;
    last_load_cyc = -1; first_vld_cyc = -1; last_c_cyc = -1;
    stall_viol = 0; timed_out = 0;
    @(negedge clk);
    cfg_m = DIM_W'(m); cfg_n = DIM_W'(n); cfg_k = DIM_W'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_first = int'(err);
    while (!seen_done && !stop) begin
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
      a_tvalid = (ai < na);
      a_tdata  = (ai < na) ? a_vec[ai] : '0;
      a_tlast  = (ai == na - 1);
      b_tvalid = (bi < nb);
      b_tdata  = (bi < nb) ? b_vec[bi] : '0;
      b_tlast  = (bi == nb - 1) != (bi == bad_b_beat);
      c_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (first_rdy_cyc < 0 && (a_tready || b_tready)) first_rdy_cyc = cyc;
      a_f = a_tvalid && a_tready;
      b_f = b_tvalid && b_tready;
      c_f = c_tvalid && c_tready;
      if (a_f || b_f) last_load_cyc = cyc;
      if (c_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall && (!c_tvalid || c_tdata !== prev_data || c_tlast !== prev_last))
        stall_viol++;
      prev_stall = c_tvalid && !c_tready;
      prev_data  = c_tdata;
      prev_last  = c_tlast;
      if (done) begin
        seen_done   = 1;
        done_cyc    = cyc;
        err_at_done = int'(err);
      end
      if (c_f && n_got < 64) begin
        got_c[n_got]    = c_tdata;
        got_c32[n_got]  = c_tdata32;
        got_last[n_got] = c_tlast;
        got_cyc[n_got]  = cyc;
        last_c_cyc      = cyc;
        n_got++;
        if (n_got == stop_after) stop = 1;
      end
      @(negedge clk);
      cyc++;
      if (a_f) ai++;
      if (b_f) bi++;
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0; a_tlast = 1'b0; b_tlast = 1'b0;
  endtask

  task automatic load_basic_vectors();
    a_vec[0] = 16'd1; a_vec[1] = 16'd2; a_vec[2] = 16'd3; a_vec[3] = 16'd4;
    b_vec[0] = 16'd5; b_vec[1] = 16'd6; b_vec[2] = 16'd7; b_vec[3] = 16'd8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_tready !== 1'b0 || b_tready !== 1'b0)
      $display("FAIL reset_tready: got a=%b b=%b expected 0 0", a_tready, b_tready);
    n_checks++;
    if (c_tvalid !== 1'b0 || c_tlast !== 1'b0 || c_tdata !== '0)
      $display("FAIL reset_c: got v=%b l=%b d=%h expected 0 0 0", c_tvalid, c_tlast, c_tdata);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_status: got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
    n_checks++;
    if (a_tready32 !== 1'b0 || b_tready32 !== 1'b0 || c_tvalid32 !== 1'b0 || c_tlast32 !== 1'b0 ||
        c_tdata32 !== '0 || busy32 !== 1'b0 || done32 !== 1'b0 || err32 !== 1'b0)
      $display("FAIL reset_acc32: got v=%b d=%h busy=%b expected 0 0 0", c_tvalid32, c_tdata32, busy32);
    if (n_checks != 4) n_fail++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    if (busy !== 1'b0 || a_tready !== 1'b0 || c_tvalid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        c_tdata !== '0 || c_tlast !== 1'b0 || b_tready !== 1'b0) n_fail++;
  endtask

  task automatic test_basic();
    int exp_c[4] = '{19, 22, 43, 50};
    load_basic_vectors();
    run_job(2, 2, 2, -1, 1'b0, 0);
    n_checks++;
    if (timed_out != 0 || n_got != 4) begin
      n_fail++; $display("FAIL basic_count: got %0d outputs timeout=%0d expected 4 outputs", n_got, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_c[i] !== 40'(exp_c[i]) || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_c%0d: got %0d last=%b expected %0d last=%b", i, got_c[i], got_last[i], exp_c[i], i == 3);
      end
      n_checks++;
      if (got_c32[i] !== 32'(exp_c[i])) begin
        n_fail++; $display("FAIL basic_acc32_c%0d: got %0d expected %0d", i, got_c32[i], exp_c[i]);
      end
    end
    n_checks++;
    if (err_first != 0 || err_at_done != 0) begin
      n_fail++; $display("FAIL basic_err: got start=%0d done=%0d expected 0 0", err_first, err_at_done);
    end
    n_checks++;
    if (first_rdy_cyc != 0) begin
      n_fail++; $display("FAIL basic_tready_latency: got cycle %0d expected 0", first_rdy_cyc);
    end
    n_checks++;
    if (first_vld_cyc != last_load_cyc + 3) begin
      n_fail++; $display("FAIL basic_first_c_latency: got %0d expected %0d", first_vld_cyc - last_load_cyc, 3);
    end
    n_checks++;
    if (got_cyc[1] - got_cyc[0] != 3) begin
      n_fail++; $display("FAIL basic_elem_spacing: got %0d expected 3", got_cyc[1] - got_cyc[0]);
    end
    n_checks++;
    if (done_cyc != last_c_cyc + 1) begin
      n_fail++; $display("FAIL basic_done_timing: got %0d expected %0d", done_cyc, last_c_cyc + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_fall: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_rect_backpressure();
    int exp_c[12] = '{1, -1, 2, -2, 2, -2, 4, -4, 3, -3, 6, -6};
    a_vec[0] = 16'd1; a_vec[1] = 16'd2; a_vec[2] = 16'd3;
    b_vec[0] = 16'd1; b_vec[1] = 16'hFFFF; b_vec[2] = 16'd2; b_vec[3] = 16'hFFFE;
    run_job(3, 4, 1, -1, 1'b1, 0);
    n_checks++;
    if (timed_out != 0 || n_got != 12) begin
      n_fail++; $display("FAIL rect_count: got %0d outputs timeout=%0d expected 12", n_got, timed_out);
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (got_c[i] !== 40'(exp_c[i]) || got_last[i] !== (i == 11)) begin
        n_fail++;
        $display("FAIL rect_c%0d: got %h last=%b expected %h last=%b", i, got_c[i], got_last[i], 40'(exp_c[i]), i == 11);
      end
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL rect_stall_stability: got %0d violations expected 0", stall_viol);
    end
    n_checks++;
    if (err_at_done != 0) begin
      n_fail++; $display("FAIL rect_err: got %0d expected 0", err_at_done);
    end
  endtask

  task automatic test_signed_extremes();
    for (int i = 0; i < 8; i++) a_vec[i] = 16'h8000;
    for (int i = 0; i < 16; i++) b_vec[i] = 16'h8000;
    run_job(1, 2, 8, -1, 1'b0, 0);
    n_checks++;
    if (timed_out != 0 || n_got != 2) begin
      n_fail++; $display("FAIL extreme_count: got %0d outputs timeout=%0d expected 2", n_got, timed_out);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_c[i] !== 40'h02_0000_0000) begin
        n_fail++; $display("FAIL extreme_acc40_c%0d: got %h expected 0200000000", i, got_c[i]);
      end
      n_checks++;
      if (got_c32[i] !== 32'h0) begin
        n_fail++; $display("FAIL extreme_acc32_c%0d: got %h expected 00000000", i, got_c32[i]);
      end
    end
  endtask

  task automatic test_bad_config();
    int dims[2][3] = '{'{2, 2, 0}, '{9, 2, 2}};
    for (int t = 0; t < 2; t++) begin
      run_job(dims[t][0], dims[t][1], dims[t][2], -1, 1'b0, 0);
      n_checks++;
      if (first_rdy_cyc != -1 || n_got != 0) begin
        n_fail++; $display("FAIL badcfg%0d_no_traffic: got tready cycle %0d outputs %0d expected -1 0", t, first_rdy_cyc, n_got);
      end
      n_checks++;
      if (done_cyc != 1) begin
        n_fail++; $display("FAIL badcfg%0d_done_timing: got cycle %0d expected 1", t, done_cyc);
      end
      n_checks++;
      if (err_at_done != 1 || err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL badcfg%0d_err: got err_done=%0d err=%b busy=%b expected 1 1 0", t, err_at_done, err, busy);
      end
    end
    load_basic_vectors();
    run_job(2, 2, 2, -1, 1'b0, 0);
    n_checks++;
    if (err_first != 0 || err_at_done != 0 || n_got != 4 || got_c[3] !== 40'd50) begin
      n_fail++; $display("FAIL badcfg_recover: got err=%0d/%0d outputs=%0d last=%0d expected 0/0 4 50", err_first, err_at_done, n_got, got_c[3]);
    end
  endtask

  task automatic test_framing();
    int exp_c[4] = '{19, 22, 43, 50};
    load_basic_vectors();
    run_job(2, 2, 2, 1, 1'b0, 0);
    n_checks++;
    if (err_at_done != 1 || err_first != 0) begin
      n_fail++; $display("FAIL framing_err: got start=%0d done=%0d expected 0 1", err_first, err_at_done);
    end
    n_checks++;
    if (n_got != 4) begin
      n_fail++; $display("FAIL framing_count: got %0d expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_c[i] !== 40'(exp_c[i])) begin
        n_fail++; $display("FAIL framing_c%0d: got %0d expected %0d", i, got_c[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid_output();
    int w = 0;
    int exp_c[4] = '{19, 22, 43, 50};
    load_basic_vectors();
    run_job(2, 2, 2, -1, 1'b0, 1);
    n_checks++;
    if (timed_out != 0 || n_got != 1) begin
      n_fail++; $display("FAIL midreset_first: got %0d outputs expected 1", n_got);
    end
    c_tready = 1'b0;
    while (!c_tvalid && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (c_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_wait_valid: got tvalid=%b expected 1", c_tvalid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (c_tvalid !== 1'b0 || c_tdata !== '0 || c_tlast !== 1'b0) begin
      n_fail++; $display("FAIL midreset_c: got v=%b d=%h l=%b expected 0 0 0", c_tvalid, c_tdata, c_tlast);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || a_tready !== 1'b0 || b_tready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
    end
    rst_n = 1'b1;
    c_tready = 1'b1;
    @(negedge clk);
    run_job(2, 2, 2, -1, 1'b0, 0);
    n_checks++;
    if (n_got != 4) begin
      n_fail++; $display("FAIL midreset_rerun_count: got %0d expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_c[i] !== 40'(exp_c[i])) begin
        n_fail++; $display("FAIL midreset_rerun_c%0d: got %0d expected %0d", i, got_c[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_rect_backpressure();
    test_signed_extremes();
    test_bad_config();
    test_framing();
    test_reset_mid_output();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_matmul_engine.md
# axis_matmul_engine

Parametrised streaming matrix-multiply core for the AXI matrix accelerator: computes C = A·B for runtime dimensions M×K by K×N, up to MAX_DIM each. A and B arrive row-major on two AXI-Stream slaves and are buffered on chip. C leaves row-major on an AXI-Stream master with full backpressure support. It sits behind the AXI-Lite control wrapper, which drives start and the cfg_* registers and samples busy/done/err. This block generalises the fixed-K compute core: configurable M/N/K, signed arithmetic, framing-error detection and a configurable accumulator width.

## Interface
- DATA_W, 16, signed element width of A and B
- ACC_W, 40, signed accumulator and C element width (ACC_W ≥ 2·DATA_W)
- MAX_DIM, 8, maximum value of M, N, K
- DIM_W, $clog2(MAX_DIM+1), width of the cfg_* inputs
- clk  in  1  clock, all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle start request, honoured only in IDLE
- cfg_m, cfg_n, cfg_k  in  DIM_W each  matrix dimensions, latched on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared on the next accepted start
- s_axis_a_tvalid/tready/tlast  in/out/in  1 each; s_axis_a_tdata  in  DATA_W
- s_axis_b_tvalid/tready/tlast  in/out/in  1 each; s_axis_b_tdata  in  DATA_W
- m_axis_c_tvalid/tready/tlast  out/in/out  1 each; m_axis_c_tdata  out  ACC_W

## Operation
- States: IDLE, LOAD, COMPUTE, OUTPUT, FINISH.
- IDLE → LOAD on start. cfg values are latched and err is cleared in the same cycle.
- Invalid config: if any cfg is 0 or > MAX_DIM, go IDLE → FINISH instead. Set err and load nothing.
- LOAD, buffering:
  - A takes M·K beats into a MAX_DIM² buffer at index i·K+k.
  - B takes K·N beats into a MAX_DIM² buffer at index k·N+j.
  - The two streams are independent and may interleave arbitrarily.
- LOAD, handshakes:
  - Each tready is high while that stream's received count is below its expected count, and low otherwise.
  - A beat transfers on tvalid&&tready.
- LOAD, framing:
  - Framing is by count only.
  - tlast asserted on a non-final beat, or deasserted on the final beat, sets err. Loading continues regardless.
- LOAD → COMPUTE when both counts are complete.
- COMPUTE, per element (i, j):
  - Clear acc, then perform K MACs, one per cycle: acc += sext(A[i][k]·B[k][j]).
  - Multiplication is signed. Accumulation wraps modulo 2^ACC_W; there is no saturation.
- COMPUTE → OUTPUT after the K-th MAC.
- OUTPUT, on a C handshake:
  - Drive tvalid=1, tdata=acc, and tlast=1 only when (i, j) = (M−1, N−1).
  - On the handshake, advance j, then i, and return to COMPUTE.
  - After the last element, go to FINISH.
- FINISH: pulse done for one cycle, then go to IDLE.

## Timing
- Reset values: all tready 0, m_axis_c_tvalid 0, tdata 0, tlast 0, busy 0, done 0, err 0; state IDLE; counters 0.
- Reset applies at any time, including mid-LOAD and mid-OUTPUT: next state IDLE, tvalid drops immediately, buffered data is discarded.
- start → first tready high: 1 cycle.
- start is ignored while busy=1.
- Last load beat → first C tvalid: K+1 cycles.
- Each subsequent element: K cycles after the previous handshake, plus 1.
- C stability: while tvalid=1 and tready=0, tdata and tlast must stay stable. tvalid never drops without a handshake.
- Full throughput is not required; tready may be held high continuously.
- Final C handshake → done=1 on the next cycle. busy falls in the cycle after done.
- Invalid config: done pulses 2 cycles after start; err=1 from the cycle of the done pulse.
- Inputs with tvalid while tready=0 are not consumed.

## Test plan
- **Basic 2×2×2:** A=[1,2,3,4], B=[5,6,7,8] with correct tlast and C tready held high → C=19,22,43,50, tlast on 50 only, done pulse, err=0.
- **Rectangular with backpressure:** M=3, K=1, N=4, A=[1,2,3], B=[1,−1,2,−2], C tready random 50% → 12 outputs [1,−1,2,−2,2,−2,4,−4,3,−3,6,−6]. Checker confirms tdata is stable during every stall.
- **Signed extremes:** K=MAX_DIM=8, all A=−32768, all B=−32768 → each C = 8·2^30 = 2^33. No wrap at ACC_W=40. Repeat with ACC_W=32: C wraps to 0.
- **Bad config:** cfg_k=0, then cfg_m=9 → no tready, err=1, done 2 cycles after start. A following valid start clears err.
- **Framing error:** B tlast asserted on beat 1 of 4 in a 2×2×2 run → err=1, results still 19,22,43,50.
- **Reset mid-OUTPUT:** assert rst_n=0 after the first C handshake → all outputs at reset values. A fresh 2×2×2 run then produces the correct results.
